led_pio_fader: RTL and testbench
================================

# led_pio_fader

Soft-fade PWM driver placed directly downstream of the 4-bit LED PIO. It consumes the PIO's `out_port` word as per-LED on/off targets and drives the physical LEDs. Each LED ramps its brightness linearly toward full-on or full-off instead of switching abruptly. The block has no bus interface: software keeps writing the PIO, and this block only shapes the visible result.

## Interface
Parameters:
- `LED_W`, 4, number of LED channels; must equal the PIO output width.
- `PWM_W`, 8, PWM counter width; legal range 2..16. The PWM period is 2^PWM_W cycles.
- `RAMP_DIV`, 1024, clock cycles per brightness step; must be ≥1.

Ports:
- `clk`, in, 1: single system clock; every register is on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `led_in`, in, LED_W: per-channel target from the PIO `out_port` (1 = on, 0 = off); synchronous to `clk`.
- `led_out`, out, LED_W: PWM-modulated LED drive, registered.
- `ramping`, out, LED_W: channel i brightness has not reached its target.
- `pwm_sync`, out, 1: registered one-cycle pulse on each PWM counter wrap.

## Operation
- `led_in_q`: a LED_W register that samples `led_in` every cycle. All target decisions use `led_in_q`.
- `pwm_cnt`: PWM_W bits, free-running, increments every cycle and wraps from 2^PWM_W−1 to 0.
- `pre_cnt`: prescaler that counts 0..RAMP_DIV−1. `tick` = (`pre_cnt` == RAMP_DIV−1); `pre_cnt` returns to 0 on the same edge. With RAMP_DIV=1, `tick` is high every cycle.
- `bright[i]`: PWM_W+1 bits, range 0..MAX where MAX = 2^PWM_W.
- Per-channel ramp rule, applied only on cycles where `tick` is high:
  - if `led_in_q[i]` = 1 and `bright[i]` < MAX: `bright[i]` +1;
  - if `led_in_q[i]` = 0 and `bright[i]` > 0: `bright[i]` −1;
  - otherwise `bright[i]` holds. It never saturates past MAX and never underflows below 0.
- Target reversal mid-ramp: direction changes at the next `tick` from the current value. There is no jump and no restart.
- `led_out[i]` <= (`pwm_cnt` < `bright[i]`), compared zero-extended:
  - `bright[i]` = 0 gives constant 0;
  - `bright[i]` = MAX gives constant 1;
  - otherwise duty = `bright[i]`/2^PWM_W.
- `ramping[i]` = (`bright[i]` != (`led_in_q[i]` ? MAX : 0)), combinational from registers.
- `pwm_sync` <= (`pwm_cnt` == 2^PWM_W−1).
- Channels are independent; any combination may ramp simultaneously in either direction.

## Timing
- Reset asserted: asynchronously clears `led_in_q`, `pwm_cnt`, `pre_cnt`, all `bright`, `led_out`, and `pwm_sync` to 0. Consequently `ramping` = 0.
- Reset mid-ramp: all channels go dark immediately, with no fade-out.
- First edge after reset release: `pwm_cnt` = 1, `pre_cnt` = 1 (or 0 if RAMP_DIV=1).
- `led_in` change at edge k: visible in `led_in_q` after edge k+1. `ramping` reflects the new target in the cycle after edge k+1.
- `bright` step: first step on the first `tick` edge after edge k+1. The step is visible in `led_out` one edge later.
- Full 0→MAX ramp: exactly 2^PWM_W ticks, i.e. 2^PWM_W·RAMP_DIV cycles (≈262k cycles at defaults, ≈5.2 ms at 50 MHz).
- Target pulse shorter than one cycle of `led_in_q` sampling: ignored. A pulse of one or more cycles that spans a `tick` produces exactly the steps taken while it is held.
- `pwm_sync`: high for one cycle every 2^PWM_W cycles, in the cycle after `pwm_cnt` = 2^PWM_W−1.

## Test plan
Run all scenarios with PWM_W=4 and RAMP_DIV=4 (MAX=16, full ramp = 64 cycles).
- Reset, then hold `led_in`=0 for 100 cycles -> `led_out`=0, `ramping`=0, `pwm_sync` pulses every 16 cycles.
- `led_in`=4'b0001 -> `ramping[0]`=1 until `bright[0]` reaches 16 after 16 ticks. Then `led_out[0]` stays constantly 1 and `ramping[0]`=0. Check the duty at `bright[0]`=8 is 8/16 high.
- All four channels full on, then `led_in`=0 -> each channel decrements by 1 per tick and reaches 0 after 64 cycles. Afterwards `led_out`=0 and `ramping`=0.
- Channel 1 ramps up to `bright`=5, then `led_in[1]` drops -> the next tick gives 4 with no jump. The channel reaches 0 after 5 more ticks.
- Mixed directions: channel 0 rising while channel 2 falls from 16 -> independent counts with correct per-channel duty each PWM period.
- Assert `reset` asynchronously (mid-cycle) while all channels are at `bright`=10 -> `led_out`=0 and `pwm_sync`=0 immediately. After release, fading restarts from 0 toward `led_in`.

Source files
------------

// File: rtl/led_pio_fader.sv
// Soft-fade PWM driver for the LED PIO: each channel ramps its brightness linearly
// toward the on/off target sampled from led_in and drives a PWM-modulated LED.
module led_pio_fader #(
    parameter int LED_W    = 4,
    parameter int PWM_W    = 8,
    parameter int RAMP_DIV = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LED_W-1:0] led_in,
    output logic [LED_W-1:0] led_out,
    output logic [LED_W-1:0] ramping,
    output logic             pwm_sync
);

    localparam int              PRE_W      = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(RAMP_DIV - 1);
    localparam logic [PWM_W:0]  BRIGHT_MAX = {1'b1, {PWM_W{1'b0}}};
    localparam logic [PWM_W-1:0] PWM_LAST  = '1;

    logic [LED_W-1:0]            led_in_q_reg;
    logic [PWM_W-1:0]            pwm_cnt_reg;
    logic [PRE_W-1:0]            pre_cnt_reg;
    logic [PRE_W-1:0]            pre_cnt_next;
    logic                        tick;
    logic [LED_W-1:0][PWM_W:0]   bright_reg;
    logic [LED_W-1:0][PWM_W:0]   bright_next;
    logic [LED_W-1:0]            led_out_next;

    // With RAMP_DIV=1 the single prescaler bit stays at 0 and tick is permanently high.
    assign tick         = (pre_cnt_reg == PRE_LAST);
    assign pre_cnt_next = tick ? '0 : pre_cnt_reg + PRE_W'(1);

    generate
        for (genvar gi = 0; gi < LED_W; gi++) begin : g_chan
            assign bright_next[gi] =
                !tick                                             ? bright_reg[gi] :
                ( led_in_q_reg[gi] && bright_reg[gi] != BRIGHT_MAX) ? bright_reg[gi] + (PWM_W+1)'(1) :
                (!led_in_q_reg[gi] && bright_reg[gi] != '0)         ? bright_reg[gi] - (PWM_W+1)'(1) :
                                                                    bright_reg[gi];

            // Zero-extended compare: bright == MAX is above every counter value, so fully on.
            assign led_out_next[gi] = ({1'b0, pwm_cnt_reg} < bright_reg[gi]);

            assign ramping[gi] = (bright_reg[gi] != (led_in_q_reg[gi] ? BRIGHT_MAX : '0));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_in_q_reg <= '0;
            pwm_cnt_reg  <= '0;
            pre_cnt_reg  <= '0;
            bright_reg   <= '0;
            led_out      <= '0;
            pwm_sync     <= 1'b0;
        end else begin
            led_in_q_reg <= led_in;
            pwm_cnt_reg  <= pwm_cnt_reg + PWM_W'(1);
            pre_cnt_reg  <= pre_cnt_next;
            bright_reg   <= bright_next;
            led_out      <= led_out_next;
            pwm_sync     <= (pwm_cnt_reg == PWM_LAST);
        end
    end

endmodule

// File: tb/tb_led_pio_fader.sv
// Directed bench for led_pio_fader at PWM_W=4, RAMP_DIV=4 (MAX=16, tick every 4 cycles).
module tb_led_pio_fader;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic [3:0] led_in = 4'b0000;
    logic [3:0] led_out;
    logic [3:0] ramping;
    logic       pwm_sync;

    int cyc     = 0;
    int err_cnt = 0;
    int chk_cnt = 0;

    led_pio_fader #(
        .LED_W    (4),
        .PWM_W    (4),
        .RAMP_DIV (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .led_in   (led_in),
        .led_out  (led_out),
        .ramping  (ramping),
        .pwm_sync (pwm_sync)
    );

    always #5 clk = ~clk;

    // Edges since the last reset release; all cycle numbers below refer to this.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
        end else begin
            $display("ok   %s: %0d (cyc %0d)", tag, obs, cyc);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Brightness of a channel that started rising from 0 when led_in was set at cycle
    // 'start': +1 at edges start+4, start+8, ... , saturating at 16.
    function automatic int b_up(input int m, input int start);
        int k;
        if (m < start) return 0;
        k = (m - start) / 4;
        return (k > 16) ? 16 : k;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e_out, e_ramp, e_sync, n_sync;
        int e_lo, duty0, duty2, on_cnt;
        logic exp0, exp2;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_led_out",  32'(led_out),  32'd0);
        check_eq("rst_ramping",  32'(ramping),  32'd0);
        check_eq("rst_pwm_sync", 32'(pwm_sync), 32'd0);
        reset = 1'b0;
        goto(1);
        check_eq("first_pwm_cnt", 32'(dut.pwm_cnt_reg), 32'd1);
        check_eq("first_pre_cnt", 32'(dut.pre_cnt_reg), 32'd1);

        // Idle: dark, not ramping, pwm_sync after edges 16, 32, ...
        e_out = 0; e_ramp = 0; e_sync = 0; n_sync = 0;
        for (int n = 1; n <= 100; n++) begin
            goto(n);
            if (led_out != 4'b0000) e_out++;
            if (ramping != 4'b0000) e_ramp++;
            if (pwm_sync !== ((n % 16) == 0)) e_sync++;
            if (pwm_sync) n_sync++;
        end
        check_eq("idle_led_out_errs", 32'(e_out),  32'd0);
        check_eq("idle_ramping_errs", 32'(e_ramp), 32'd0);
        check_eq("idle_sync_pos_errs", 32'(e_sync), 32'd0);
        check_eq("idle_sync_count",   32'(n_sync), 32'd6);

        // Channel 0 ramps up from cycle 100
        led_in = 4'b0001;
        e_lo = 0; duty0 = 0; on_cnt = 0;
        for (int n = 101; n <= 184; n++) begin
            goto(n);
            exp0 = ((n - 1) % 16) < b_up(n - 1, 100);
            if (led_out !== {3'b000, exp0}) e_lo++;
            if (n >= 129 && n <= 144) duty0 += int'(led_out[0]);
            if (n >= 165 && n <= 180) on_cnt += int'(led_out[0]);
            if (n == 101) check_eq("up_ramping_start", 32'(ramping), 32'b0001);
            if (n == 103) check_eq("up_bright_pretick", 32'(dut.bright_reg[0]), 32'd0);
            if (n == 104) check_eq("up_bright_first",  32'(dut.bright_reg[0]), 32'd1);
            if (n == 132) check_eq("up_bright_half",   32'(dut.bright_reg[0]), 32'd8);
            if (n == 163) check_eq("up_ramping_late",  32'(ramping), 32'b0001);
            if (n == 164) check_eq("up_bright_max",    32'(dut.bright_reg[0]), 32'd16);
            if (n == 164) check_eq("up_ramping_done",  32'(ramping), 32'b0000);
        end
        check_eq("up_led_out_errs", 32'(e_lo), 32'd0);
        check_eq("up_duty_mid",     32'(duty0), 32'd9);
        check_eq("up_full_on",      32'(on_cnt), 32'd16);

        // All channels on, then all off
        led_in = 4'b1111;
        goto(247);
        check_eq("all_ramping_247", 32'(ramping), 32'b1110);
        check_eq("all_bright1_247", 32'(dut.bright_reg[1]), 32'd15);
        goto(248);
        check_eq("all_bright3_max", 32'(dut.bright_reg[3]), 32'd16);
        check_eq("all_ramping_248", 32'(ramping), 32'b0000);
        led_in = 4'b0000;
        goto(249);
        check_eq("dn_ramping_start", 32'(ramping), 32'b1111);
        goto(252);
        check_eq("dn_bright0_first", 32'(dut.bright_reg[0]), 32'd15);
        check_eq("dn_bright2_first", 32'(dut.bright_reg[2]), 32'd15);
        goto(311);
        check_eq("dn_bright1_last", 32'(dut.bright_reg[1]), 32'd1);
        goto(312);
        check_eq("dn_bright3_zero", 32'(dut.bright_reg[3]), 32'd0);
        check_eq("dn_ramping_done", 32'(ramping), 32'b0000);
        e_out = 0;
        for (int n = 313; n <= 328; n++) begin
            goto(n);
            if (led_out != 4'b0000) e_out++;
        end
        check_eq("dn_dark_errs", 32'(e_out), 32'd0);

        // Channel 1 reverses at brightness 5
        led_in = 4'b0010;
        goto(348);
        check_eq("rev_bright_peak", 32'(dut.bright_reg[1]), 32'd5);
        led_in = 4'b0000;
        goto(351);
        check_eq("rev_bright_hold", 32'(dut.bright_reg[1]), 32'd5);
        goto(352);
        check_eq("rev_bright_step", 32'(dut.bright_reg[1]), 32'd4);
        goto(367);
        check_eq("rev_ramping_late", 32'(ramping), 32'b0010);
        goto(368);
        check_eq("rev_bright_zero", 32'(dut.bright_reg[1]), 32'd0);
        check_eq("rev_ramping_done", 32'(ramping), 32'b0000);

        // Channel 2 to full, then channel 0 rises while channel 2 falls
        led_in = 4'b0100;
        goto(432);
        check_eq("mix_bright2_full", 32'(dut.bright_reg[2]), 32'd16);
        led_in = 4'b0001;
        e_lo = 0; duty0 = 0; duty2 = 0;
        for (int n = 433; n <= 496; n++) begin
            goto(n);
            exp0 = ((n - 1) % 16) < b_up(n - 1, 432);
            exp2 = ((n - 1) % 16) < (16 - b_up(n - 1, 432));
            if (led_out !== {1'b0, exp2, 1'b0, exp0}) e_lo++;
            if (n >= 449 && n <= 464) begin
                duty0 += int'(led_out[0]);
                duty2 += int'(led_out[2]);
            end
            if (n == 448) check_eq("mix_bright0_448", 32'(dut.bright_reg[0]), 32'd4);
            if (n == 448) check_eq("mix_bright2_448", 32'(dut.bright_reg[2]), 32'd12);
            if (n == 448) check_eq("mix_ramping_448", 32'(ramping), 32'b0101);
        end
        check_eq("mix_led_out_errs", 32'(e_lo), 32'd0);
        check_eq("mix_duty_ch0",     32'(duty0), 32'd5);
        check_eq("mix_duty_ch2",     32'(duty2), 32'd10);
        check_eq("mix_bright0_end",  32'(dut.bright_reg[0]), 32'd16);
        check_eq("mix_bright2_end",  32'(dut.bright_reg[2]), 32'd0);
        check_eq("mix_ramping_end",  32'(ramping), 32'b0000);

        // All channels to 10, then reset mid-cycle
        led_in = 4'b0000;
        goto(560);
        check_eq("pre_rst_bright0_zero", 32'(dut.bright_reg[0]), 32'd0);
        led_in = 4'b1111;
        goto(600);
        check_eq("pre_rst_bright0", 32'(dut.bright_reg[0]), 32'd10);
        check_eq("pre_rst_bright3", 32'(dut.bright_reg[3]), 32'd10);
        check_eq("pre_rst_led_out", 32'(led_out), 32'b1111);
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_led_out",  32'(led_out),  32'd0);
        check_eq("async_rst_pwm_sync", 32'(pwm_sync), 32'd0);
        check_eq("async_rst_ramping",  32'(ramping),  32'd0);
        check_eq("async_rst_bright2",  32'(dut.bright_reg[2]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        goto(1);
        check_eq("restart_ramping", 32'(ramping), 32'b1111);
        check_eq("restart_pwm_cnt", 32'(dut.pwm_cnt_reg), 32'd1);
        goto(3);
        check_eq("restart_bright_pretick", 32'(dut.bright_reg[0]), 32'd0);
        goto(4);
        check_eq("restart_bright_first", 32'(dut.bright_reg[1]), 32'd1);
        goto(40);
        check_eq("restart_bright_40", 32'(dut.bright_reg[3]), 32'd10);
        check_eq("restart_led_out_40", 32'(led_out), 32'b1111);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
